text_plane_buffer: RTL and testbench
====================================

# text_plane_buffer

Parametrised character-plane memory for the text display: a ROWS×COLS array of character codes written through a cursor-driven command port and read through a registered display port. It supersedes the fixed 7×20 plane by adding automatic cursor advance, newline, backspace, full-screen clear and hardware scroll-up when text runs past the last row. It sits between the character/keyboard decoder (writer) and the glyph renderer (reader).

## Interface

- COLS, 20, characters per row (≥2)
- ROWS, 7, rows per plane (≥2)
- DW, 8, character code width
- BLANK, 129, code stored for an empty cell
- ERASE, 8'hFF, incoming code that is stored as BLANK
- Derived: N = ROWS*COLS; CW = $clog2(COLS); RW = $clog2(ROWS); AW = $clog2(N)

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  command present
- wr_op  in  2  0 PUT, 1 NEWLINE, 2 BACKSPACE, 3 CLEAR
- wr_char  in  DW  character for PUT (ignored otherwise)
- wr_ready  out  1  high when a command can be accepted
- rd_row  in  RW  display read row
- rd_col  in  CW  display read column
- rd_data  out  DW  cell contents, one cycle after address
- cur_row  out  RW  cursor row
- cur_col  out  CW  cursor column
- scrolled  out  1  one-cycle pulse when a scroll sweep completes

## Operation

- Address of cell (r,c) = r*COLS + c.
- Command accepted on a posedge where wr_valid && wr_ready. wr_ready = (state == IDLE).
- States: IDLE, SCROLL, CLEAR. Sweep index idx runs 0..N-1, one cell per cycle.
- PUT: store wr_char at cursor (ERASE → BLANK); then col+1; at col == COLS-1 → col 0, row+1; if row was ROWS-1 → cursor (ROWS-1,0), enter SCROLL.
- NEWLINE: col 0; row+1, or if row == ROWS-1 → cursor (ROWS-1,0), enter SCROLL.
- BACKSPACE: col>0 → col-1 and store BLANK there; col 0 and row>0 → (row-1, COLS-1), store BLANK there; at (0,0) no-op.
- CLEAR: cursor (0,0), enter CLEAR.
- SCROLL: each cycle, idx < N-COLS → mem[idx] = mem[idx+COLS]; else mem[idx] = BLANK. After idx = N-1 → IDLE, scrolled pulses.
- CLEAR: each cycle mem[idx] = BLANK. After idx = N-1 → IDLE (no scrolled pulse).
- Read port: rd_data <= mem[rd_row*COLS + rd_col]; rd_row ≥ ROWS or rd_col ≥ COLS returns BLANK. Reads are always serviced, including during sweeps (intermediate contents visible).
- Cursor does not change during sweeps.

## Timing

- Reset (any state, including mid-sweep): state CLEAR, idx 0, cursor (0,0), rd_data BLANK, scrolled 0, wr_ready 0; a full CLEAR sweep follows. Reset dominates wr_valid. Memory contents undefined only until that sweep completes.
- Reset released before edge 0: sweep writes on edges 0..N-1; wr_ready high from edge N onward.
- Non-scrolling command accepted at edge k: memory and cursor updated at k; wr_ready stays high; next command may be accepted at k+1.
- Scrolling/CLEAR command accepted at edge k: cell write (if any) and cursor at k; wr_ready low after k; sweep writes at edges k+1..k+N; wr_ready high after k+N; scrolled high for the cycle after k+N (SCROLL only).
- The PUT that triggers a scroll writes its character before the sweep, so it ends at (ROWS-2, COLS-1).
- Read latency exactly 1 cycle; simultaneous write and read of the same cell returns the old value.
- Cursor counters never exceed COLS-1 / ROWS-1; no wrap to row 0 ever occurs.

## Test plan

- Reset, wait N cycles → wr_ready rises at cycle N; every cell reads 129; cursor (0,0).
- PUT 'A'(0x41),'B'(0x42), BACKSPACE → (0,0)=0x41, (0,1)=129, cursor (0,1); BACKSPACE at (0,0) twice → no change.
- 20 PUTs of 0x30 at default size → cursor (1,0), row 0 all 0x30; PUT 0xFF → (1,0)=129, cursor (1,1).
- Fill to (6,19) with row code 0x40+r, PUT 0x5A → wr_ready low 140 cycles, scrolled pulse; rows 0..5 hold 0x41..0x46 (row 5 col 19 = 0x5A), row 6 all 129, cursor (6,0).
- NEWLINE at row 6 → same scroll behaviour; commands asserted with wr_ready low are not accepted and are held until ready.
- Assert reset halfway through a scroll → sweep restarts as CLEAR, all cells 129 after 140 cycles, cursor (0,0); out-of-range read (row 7) returns 129.

Source files
------------

// File: rtl/text_plane_buffer.sv
// rtl/text_plane_buffer.sv - cursor-driven character plane with newline, backspace, clear and scroll-up
module text_plane_buffer #(
    parameter int COLS = 20,
    parameter int ROWS = 7,
    parameter int DW = 8,
    parameter logic [DW-1:0] BLANK = DW'(129),
    parameter logic [DW-1:0] ERASE = DW'(8'hFF),
    localparam int N = ROWS * COLS,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [1:0]    wr_op,
    input  logic [DW-1:0] wr_char,
    output logic          wr_ready,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [DW-1:0] rd_data,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic          scrolled
);

    localparam logic [1:0] OP_PUT = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_BACKSPACE = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [RW-1:0] row_n;
    logic [CW-1:0] col_n;
    logic          scrolled_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [N];

    logic [AW-1:0] cur_addr, src_addr, rd_addr;
    logic          rd_in_range, last_col, last_row;

    assign cur_addr    = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
    assign src_addr    = idx + AW'(COLS);
    assign rd_addr     = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
    assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    assign last_col    = (cur_col == CW'(COLS - 1));
    assign last_row    = (cur_row == RW'(ROWS - 1));
    assign wr_ready    = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            idx      <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            rd_data  <= BLANK;
            scrolled <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cur_row  <= row_n;
            cur_col  <= col_n;
            rd_data  <= rd_in_range ? mem[rd_addr] : BLANK;
            scrolled <= scrolled_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        row_n      = cur_row;
        col_n      = cur_col;
        scrolled_n = 1'b0;
        we         = 1'b0;
        waddr      = cur_addr;
        wdata      = BLANK;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    case (wr_op)
                        OP_PUT: begin
                            we    = 1'b1;
                            wdata = (wr_char == ERASE) ? BLANK : wr_char;
                            if (last_col) begin
                                col_n = '0;
                                if (last_row) begin
                                    state_n = SCROLL;
                                    idx_n   = '0;
                                end else begin
                                    row_n = cur_row + 1'b1;
                                end
                            end else begin
                                col_n = cur_col + 1'b1;
                            end
                        end
                        OP_NEWLINE: begin
                            col_n = '0;
                            if (last_row) begin
                                state_n = SCROLL;
                                idx_n   = '0;
                            end else begin
                                row_n = cur_row + 1'b1;
                            end
                        end
                        OP_BACKSPACE: begin
                            // Both branches erase the cell just before the cursor in linear order.
                            waddr = cur_addr - 1'b1;
                            if (cur_col != '0) begin
                                we    = 1'b1;
                                col_n = cur_col - 1'b1;
                            end else if (cur_row != '0) begin
                                we    = 1'b1;
                                row_n = cur_row - 1'b1;
                                col_n = CW'(COLS - 1);
                            end
                        end
                        default: begin
                            row_n   = '0;
                            col_n   = '0;
                            state_n = CLEAR;
                            idx_n   = '0;
                        end
                    endcase
                end
            end
            SCROLL: begin
                we    = 1'b1;
                waddr = idx;
                wdata = (int'(idx) < N - COLS) ? mem[src_addr] : BLANK;
                if (int'(idx) == N - 1) begin
                    state_n    = IDLE;
                    scrolled_n = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: begin
                we    = 1'b1;
                waddr = idx;
                if (int'(idx) == N - 1) begin
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_text_plane_buffer.sv
// tb/tb_text_plane_buffer.sv - randomized bench for text_plane_buffer against a row/column plane model
module tb_text_plane_buffer;

    localparam int COLS = 20;
    localparam int ROWS = 7;
    localparam int N = ROWS * COLS;
    localparam int BLANK = 129;
    localparam int PUT = 0, NEWLINE = 1, BACKSPACE = 2, CLEAR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_op = 2'd0;
    logic [7:0] wr_char = 8'd0;
    logic       wr_ready;
    logic [2:0] rd_row = 3'd0;
    logic [4:0] rd_col = 5'd0;
    logic [7:0] rd_data;
    logic [2:0] cur_row;
    logic [4:0] cur_col;
    logic       scrolled;

    int passed = 0;
    int total = 0;
    int m [ROWS][COLS];
    int mr = 0;
    int mc = 0;

    text_plane_buffer dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_op(wr_op), .wr_char(wr_char),
        .wr_ready(wr_ready), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cur_row(cur_row), .cur_col(cur_col), .scrolled(scrolled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void m_blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m[r][c] = BLANK;
        mr = 0;
        mc = 0;
    endfunction

    function automatic void m_scroll();
        for (int r = 0; r < ROWS - 1; r++) m[r] = m[r + 1];
        for (int c = 0; c < COLS; c++) m[ROWS - 1][c] = BLANK;
    endfunction

    // Returns 0 for no sweep, 1 for a scroll, 2 for a clear.
    function automatic int m_cmd(input int op, input int ch);
        int sw = 0;
        case (op)
            PUT: begin
                m[mr][mc] = (ch == 255) ? BLANK : ch;
                if (mc == COLS - 1) begin
                    mc = 0;
                    if (mr == ROWS - 1) begin m_scroll(); sw = 1; end
                    else mr++;
                end else mc++;
            end
            NEWLINE: begin
                mc = 0;
                if (mr == ROWS - 1) begin m_scroll(); sw = 1; end
                else mr++;
            end
            BACKSPACE: begin
                if (mc > 0) begin mc--; m[mr][mc] = BLANK; end
                else if (mr > 0) begin mr--; mc = COLS - 1; m[mr][mc] = BLANK; end
            end
            default: begin m_blank_all(); sw = 2; end
        endcase
        return sw;
    endfunction

    task automatic wait_ready(input int exp_cycles, input int exp_scr, input string tag);
        int cnt = 0;
        while (!wr_ready && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, cnt, exp_cycles);
        chk({tag, "_scrolled"}, scrolled, exp_scr);
        @(negedge clk);
        chk({tag, "_scrolled_drop"}, scrolled, 0);
    endtask

    task automatic do_cmd(input int op, input int ch, input bit nowait);
        int hold = 0;
        int old;
        int sw;
        rd_row   = 3'(mr);
        rd_col   = 5'(mc);
        old      = m[mr][mc];
        wr_valid = 1'b1;
        wr_op    = 2'(op);
        wr_char  = 8'(ch);
        while (!wr_ready && hold < 1000) begin
            hold++;
            @(negedge clk);
        end
        if (hold >= 1000) chk("accept_timeout", hold, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        if (op == PUT && hold == 0) chk("rd_old_on_write", rd_data, old);
        sw = m_cmd(op, ch);
        chk("cur_row", cur_row, mr);
        chk("cur_col", cur_col, mc);
        if (sw == 0) chk("ready_after_cmd", wr_ready, 1);
        else if (!nowait) wait_ready(N, (sw == 1) ? 1 : 0, (sw == 1) ? "scroll" : "clear");
    endtask

    task automatic check_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_row = 3'(r);
                rd_col = 5'(c);
                @(negedge clk);
                chk($sformatf("cell_%0d_%0d", r, c), rd_data, m[r][c]);
            end
        chk("plane_cur_row", cur_row, mr);
        chk("plane_cur_col", cur_col, mc);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", wr_ready, 0);
        chk("rst_rd_data", rd_data, BLANK);
        chk("rst_scrolled", scrolled, 0);
        chk("rst_cur_row", cur_row, 0);
        chk("rst_cur_col", cur_col, 0);
        reset = 1'b0;
        m_blank_all();
        wait_ready(N, 0, "reset");
    endtask

    initial begin
        int op, ch, roll;
        reset_dut();
        check_all();

        do_cmd(PUT, 8'h41, 0);
        do_cmd(PUT, 8'h42, 0);
        do_cmd(BACKSPACE, 0, 0);
        check_all();
        do_cmd(BACKSPACE, 0, 0);
        do_cmd(BACKSPACE, 0, 0);
        do_cmd(BACKSPACE, 0, 0);
        check_all();

        do_cmd(CLEAR, 0, 0);
        for (int i = 0; i < COLS; i++) do_cmd(PUT, 8'h30, 0);
        do_cmd(PUT, 8'hFF, 0);
        check_all();

        do_cmd(CLEAR, 0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!(r == ROWS - 1 && c == COLS - 1)) do_cmd(PUT, 8'h40 + r, 0);
        do_cmd(PUT, 8'h5A, 0);
        check_all();

        do_cmd(NEWLINE, 0, 1);
        do_cmd(PUT, 8'h51, 0);
        check_all();

        do_cmd(CLEAR, 0, 0);
        for (int i = 0; i < ROWS - 1; i++) do_cmd(NEWLINE, 0, 0);
        do_cmd(PUT, 8'h77, 0);
        do_cmd(NEWLINE, 0, 1);
        repeat (70) @(negedge clk);
        reset_dut();
        check_all();
        rd_row = 3'd7;
        rd_col = 5'd0;
        @(negedge clk);
        chk("oob_row", rd_data, BLANK);
        rd_row = 3'd0;
        rd_col = 5'd25;
        @(negedge clk);
        chk("oob_col", rd_data, BLANK);

        for (int i = 0; i < 400; i++) begin
            roll = int'($urandom_range(0, 31));
            if (roll < 22) op = PUT;
            else if (roll < 26) op = NEWLINE;
            else if (roll < 31) op = BACKSPACE;
            else op = CLEAR;
            ch = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 254));
            do_cmd(op, ch, 0);
            if (i % 100 == 99) check_all();
        end
        check_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
